// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Inter-stage pipeline register with a valid/ready handshake and a 2-entry
//   skid buffer. in_ready and out_valid both decode directly from the state
//   register, so no combinational ready path runs through the stage. A flush
//   turns the stage into an all-zero bubble. A saturating counter records the
//   cycles in which a live payload was held back by downstream.
//
// Parameters
//   DATA_W    payload width in bits
//   CNT_W     stall-counter width in bits (the counter saturates at all-ones)
//
// Ports
//   CLK        in   1       clock, rising edge
//   RST        in   1       synchronous, active-high reset
//   flush      in   1       squash the contents and leave a zero bubble
//   in_valid   in   1       upstream offers in_data
//   in_ready   out  1       stage can accept this cycle (registered)
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data holds a live payload (registered)
//   out_ready  in   1       downstream accepts out_data this cycle
//   out_data   out  DATA_W  payload to the next stage (main register)
//   stall_cnt  out  CNT_W   cycles with out_valid & !out_ready since reset
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
//   high. A producer holds valid and data stable until that edge, and valid
//   never depends on ready in the same cycle.
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The state register stands in for the two valid bits:
  // main valid = (ONE | FULL), skid valid = FULL.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q,  main_d;
  logic [DATA_W-1:0]  skid_q,  skid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic push;
  logic pop;
  logic stall_sat;

  // Registered handshake outputs.
  assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

  assign push      = in_valid  && in_ready;
  assign pop       = out_valid && out_ready;
  assign stall_sat = (stall_q == {CNT_W{1'b1}});

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Any push or pop in this cycle is absorbed; the stage restarts empty
      // with zeroed registers so out_data is a nop bubble.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            // Downstream stalled: park the new beat in the skid register.
            // in_ready drops next cycle, which is why one spare entry is needed.
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (pop) begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can move the stage.
          if (pop) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Stall counter: counts flush cycles too, and sticks at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !stall_sat) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Directed checks of reset, streaming, skid, flush and counter saturation,
//   followed by a random run against a queue model of the stage contents.
//   Two instances share the stimulus: one with the default widths and one
//   with a 4-bit stall counter.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DW = 96;

  // Clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  // Default instance
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;

  // Instance with a 4-bit stall counter
  logic          s_in_ready;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [3:0]    s_stall_cnt;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16)) dut (
    .CLK       (clk),
    .RST       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(4)) dut_sat (
    .CLK       (clk),
    .RST       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .stall_cnt (s_stall_cnt)
  );

  // Scoreboard
  int            checks;
  int            failures;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  localparam logic [DW-1:0] VA = 96'hAAAA_0000_1111_2222_3333_4444;
  localparam logic [DW-1:0] VB = 96'hBBBB_5555_6666_7777_8888_9999;
  localparam logic [DW-1:0] VC = 96'hCCCC_DDDD_EEEE_FFFF_0123_4567;

  int unsigned m_stall16;
  int unsigned m_stall4;
  logic        m_push;
  logic        m_pop;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b1, VA, 1'b0, 1'b0);

    // 1: reset held two cycles with in_valid high
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_data",  out_data,  0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("idle_out_valid", out_valid, 0);

    // 2: streaming 1..8 back-to-back
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      step();
      check("stream_out_valid", out_valid, 1);
      check("stream_out_data",  out_data,  DW'(i));
      check("stream_in_ready",  in_ready,  1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_data",  out_data,  0);
    check("stream_stall_cnt",   stall_cnt, 0);

    // 3: skid
    drive(1'b1, VA, 1'b0, 1'b0);
    step();
    check("skid_a_data",  out_data,  VA);
    check("skid_a_ready", in_ready,  1);
    check("skid_a_stall", stall_cnt, 0);
    drive(1'b1, VB, 1'b0, 1'b0);
    step();
    check("skid_full_ready", in_ready,  0);
    check("skid_full_data",  out_data,  VA);
    check("skid_full_stall", stall_cnt, 1);
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    check("skid_hold_stall2", stall_cnt, 2);
    step();
    check("skid_hold_stall3", stall_cnt, 3);
    check("skid_hold_data",   out_data,  VA);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("skid_pop_b_data",  out_data,  VB);
    check("skid_pop_b_ready", in_ready,  1);
    check("skid_pop_b_valid", out_valid, 1);
    check("skid_pop_b_stall", stall_cnt, 3);
    step();
    check("skid_empty_valid", out_valid, 0);
    check("skid_empty_data",  out_data,  0);

    // 4: flush in FULL together with a push of C
    drive(1'b1, VA, 1'b0, 1'b0);
    step();
    drive(1'b1, VB, 1'b0, 1'b0);
    step();
    check("flush_pre_ready", in_ready, 0);
    drive(1'b1, VC, 1'b0, 1'b1);
    step();
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready",  in_ready,  1);
    check("flush_out_data",  out_data,  0);
    check("flush_stall",     stall_cnt, 5);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_c_valid", out_valid, 0);
      check("flush_no_c_data",  out_data,  0);
    end

    // 5: saturation of the 4-bit counter
    do_reset();
    check("sat_rst_stall", s_stall_cnt, 0);
    drive(1'b1, VA, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("sat_stall4",    s_stall_cnt, 15);
    check("sat_stall16",   stall_cnt,   20);
    check("sat_data",      s_out_data,  VA);
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    check("sat_flush_keep",  s_stall_cnt, 15);
    check("sat_flush_valid", s_out_valid, 0);
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    check("sat_hold", s_stall_cnt, 15);
    do_reset();
    check("sat_rst_clear", s_stall_cnt, 0);
    check("rst_clear16",   stall_cnt,   0);

    // 6: random traffic against the queue model
    exp_q.delete();
    m_stall16 = 0;
    m_stall4  = 0;
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 9) < 7, {$urandom(), $urandom(), $urandom()},
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      check("rnd_in_ready",  in_ready,  exp_q.size() < 2);
      check("rnd_out_valid", out_valid, exp_q.size() > 0);
      check("rnd_out_data",  out_data,  exp_q.size() > 0 ? exp_q[0] : '0);
      check("rnd_stall16",   stall_cnt,   DW'(m_stall16));
      check("rnd_stall4",    s_stall_cnt, DW'(m_stall4));
      m_push = in_valid && (exp_q.size() < 2);
      m_pop  = (exp_q.size() > 0) && out_ready;
      if (exp_q.size() > 0 && !out_ready) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4  < 15)    m_stall4++;
      end
      step();
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_pop)  void'(exp_q.pop_front());
        if (m_push) exp_q.push_back(in_data);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
